im_loader: RTL
==============

// Module: im_loader
// PURPOSE
//  Writer side of the 17-bit instruction memory: accepts a byte stream (from the UART RX path),
//  assembles 17-bit instruction words and drives the IM write port. Holds the CPU in stall while
//  loading. Replaces the file-based image preload with in-system programming.
// PARAMETERS
//  DEPTH      8192   IM depth in words; highest legal address is DEPTH-1
//  BASE_ADDR  0      first IM address written by a load
// PORTS
//  clk        in   1   system clock; all state on posedge
//  rst        in   1   asynchronous, active-high reset
//  start      in   1   1-cycle pulse; begins a load (ignored unless IDLE/DONE/ERR)
//  rx_data    in   8   stream byte
//  rx_vld     in   1   rx_data valid
//  rx_rdy     out  1   loader accepts byte; transfer when rx_vld & rx_rdy
//  im_we      out  1   IM write strobe, exactly one cycle per word
//  im_addr    out  16  IM write address
//  im_wdata   out  17  IM write data
//  busy       out  1   high from accepted start until DONE/ERR; drives CPU stall
//  done       out  1   1-cycle pulse on successful completion
//  err        out  1   sticky error flag; cleared by next accepted start
//  words      out  14  count of words written in the current/last load
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, im_addr=BASE_ADDR.
//  Frame: CNT_HI, CNT_LO (N, 16b big-endian), then N x {B0,B1,B2}. Word = {B0[0],B1,B2}.
//    B0[7:1] ignored.
//  States: IDLE -start-> HDR0 -> HDR1 -> (N==0 ? DONE : N>DEPTH-BASE_ADDR ? ERR : B0)
//    B0 -> B1 -> B2 -> WR -> (words==N ? DONE : B0); DONE/ERR -start-> HDR0.
//  rx_rdy=1 only in HDR0,HDR1,B0,B1,B2; each byte state advances only on rx_vld&rx_rdy.
//  WR: im_we=1 for exactly one cycle; im_addr/im_wdata registered, stable for the whole cycle.
//    The IM, which samples on negedge, captures them mid-cycle.
//    im_addr then increments; words increments.
//  Latency: im_we asserts the cycle after the B2 handshake. Throughput: 1 word per 4 cycles max.
//  im_addr starts at BASE_ADDR on each start; never exceeds DEPTH-1 (guaranteed by the N check).
//  done asserts the cycle DONE is entered; busy drops that same cycle.
//  ERR: busy=0, err=1, no writes; no further bytes are consumed until the next start.
//  start while busy is ignored. rx_vld with rx_rdy=0 is held off, never dropped.
//  Async rst mid-load: immediate return to IDLE, im_we deasserted.
//    Words already written stay in the IM.
// CONFIGURATION
//  IM_LOADER_CKSUM_EN defined:
//    After the last word, one extra byte CK is expected (state CK, rx_rdy=1).
//    CK must equal the XOR of all header and data bytes, else ERR.
//    done is issued only after CK passes; words are written before the check.
//  IM_LOADER_CKSUM_EN undefined:
//    No CK state; DONE follows the final WR directly.
// TESTING
//  1. Reset, start, bytes 00 01 01 AB CD -> one im_we, addr 0x0000, wdata 0x1ABCD;
//     done pulse; words=1.
//  2. N=3, rx_vld toggled randomly -> writes at 0,1,2 with correct data; rx_rdy=0 during each WR;
//     no byte lost.
//  3. Header 00 00 -> done pulse 1 cycle after HDR1, no im_we, err=0.
//  4. Header 20 01 (8193) with DEPTH=8192 -> err=1, busy=0, no im_we, rx_rdy=0; next start clears err.
//  5. rst asserted after 2 of 4 words -> all outputs 0 asynchronously;
//     a new start reloads from BASE_ADDR.
//  6. CKSUM_EN: N=1 payload 00 01 00 12 34 with CK=0x27 -> done.
//     Same payload with CK=0x00 -> err=1 and no done; 1 write in both cases.

Source files
------------

// File: rtl/im_loader.sv
// rtl/im_loader.sv - byte-stream loader assembling 17-bit words onto the instruction memory write port
// Optional trailing XOR checksum byte enabled by defining IM_LOADER_CKSUM_EN.
module im_loader #(
  parameter int DEPTH     = 8192,
  parameter int BASE_ADDR = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_vld,
  output logic        rx_rdy,
  output logic        im_we,
  output logic [15:0] im_addr,
  output logic [16:0] im_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [13:0] words
);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR0, S_HDR1, S_B0, S_B1, S_B2, S_WR, S_CK, S_DONE, S_ERR
  } state_t;

  localparam logic [31:0] LIMIT     = 32'(DEPTH - BASE_ADDR);
  localparam logic [15:0] BASE_WORD = 16'(BASE_ADDR);

  state_t      state;
  logic [7:0]  cnt_hi;
  logic [15:0] n_words;
  logic        b0_bit;
  logic [7:0]  b1;
  logic        xfer;
  logic [15:0] hdr_n;
  logic [15:0] words_inc;

  assign xfer      = rx_vld & rx_rdy;
  assign hdr_n     = {cnt_hi, rx_data};
  assign words_inc = {2'b00, words} + 16'd1;

`ifdef IM_LOADER_CKSUM_EN
  logic [7:0] ck;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      rx_rdy   <= 1'b0;
      im_we    <= 1'b0;
      im_addr  <= BASE_WORD;
      im_wdata <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      words    <= '0;
      cnt_hi   <= '0;
      n_words  <= '0;
      b0_bit   <= 1'b0;
      b1       <= '0;
`ifdef IM_LOADER_CKSUM_EN
      ck       <= '0;
`endif
    end else begin
      done  <= 1'b0;
      im_we <= 1'b0;
`ifdef IM_LOADER_CKSUM_EN
      // Running XOR covers header and data bytes; the CK byte itself is excluded.
      if (xfer && state != S_CK) ck <= ck ^ rx_data;
`endif
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state   <= S_HDR0;
            rx_rdy  <= 1'b1;
            busy    <= 1'b1;
            err     <= 1'b0;
            words   <= '0;
            im_addr <= BASE_WORD;
`ifdef IM_LOADER_CKSUM_EN
            ck      <= '0;
`endif
          end
        end
        S_HDR0: begin
          if (xfer) begin
            cnt_hi <= rx_data;
            state  <= S_HDR1;
          end
        end
        S_HDR1: begin
          if (xfer) begin
            n_words <= hdr_n;
            if (hdr_n == 16'd0) begin
              state  <= S_DONE;
              rx_rdy <= 1'b0;
              busy   <= 1'b0;
              done   <= 1'b1;
            end else if ({16'd0, hdr_n} > LIMIT) begin
              state  <= S_ERR;
              rx_rdy <= 1'b0;
              busy   <= 1'b0;
              err    <= 1'b1;
            end else begin
              state <= S_B0;
            end
          end
        end
        S_B0: begin
          if (xfer) begin
            b0_bit <= rx_data[0];
            state  <= S_B1;
          end
        end
        S_B1: begin
          if (xfer) begin
            b1    <= rx_data;
            state <= S_B2;
          end
        end
        S_B2: begin
          if (xfer) begin
            im_wdata <= {b0_bit, b1, rx_data};
            im_we    <= 1'b1;
            rx_rdy   <= 1'b0;
            state    <= S_WR;
          end
        end
        S_WR: begin
          words <= words_inc[13:0];
          if (words_inc == n_words) begin
`ifdef IM_LOADER_CKSUM_EN
            state  <= S_CK;
            rx_rdy <= 1'b1;
`else
            state  <= S_DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
`endif
          end else begin
            // Address advances only between words so it never passes DEPTH-1.
            im_addr <= im_addr + 16'd1;
            state   <= S_B0;
            rx_rdy  <= 1'b1;
          end
        end
        S_CK: begin
`ifdef IM_LOADER_CKSUM_EN
          if (xfer) begin
            rx_rdy <= 1'b0;
            busy   <= 1'b0;
            if (ck == rx_data) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
`else
          state  <= S_IDLE;
          rx_rdy <= 1'b0;
          busy   <= 1'b0;
`endif
        end
        default: begin
          state  <= S_IDLE;
          rx_rdy <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
